exhaustive_bist_ctrl: RTL and testbench
=======================================

Name: exhaustive_bist_ctrl

Overview:
Built-in self-test sequencer for a 4-input, 1-output combinational function block (inputs x1, x2, y1, y2; output b).
- On start, drives all 16 input combinations in ascending order and samples b one cycle after each vector.
- Compares each sample against a golden truth table, counts mismatches, records the first failing vector and compacts all responses into a 16-bit MISR signature.
- Sits between the test/config register block and the function under test.

Parameters:
EXPECTED_TT, 16'hFFFF, golden truth table; bit i is the expected b for vector index i
SIG_SEED, 16'hFFFF, MISR value loaded on each accepted start
SIG_POLY, 16'h1021, MISR feedback polynomial (x^16+x^12+x^5+1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin test; honoured only in IDLE or DONE
abort  input  1  cancel a run in progress
dut_x1  output  1  vector bit 3
dut_x2  output  1  vector bit 2
dut_y1  output  1  vector bit 1
dut_y2  output  1  vector bit 0
dut_b  input  1  response of the function under test
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when a run completes
pass  output  1  fail_count==0 for the last completed run; held
fail_count  output  5  mismatches in the last run (0..16)
any_fail  output  1  first_fail_vec is valid
first_fail_vec  output  4  index of the first mismatching vector
signature  output  16  MISR value after the last completed run

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; signature=0; idx=0.
- Vector mapping: {dut_x1,dut_x2,dut_y1,dut_y2} = idx[3:0], registered outputs. Vectors are driven 0 outside RUN.
- States are IDLE, RUN, DRAIN and DONE.
- IDLE/DONE + start:
  - go to RUN; idx=0; fail_count=0; any_fail=0; pass=0; signature=SIG_SEED.
  - The vector 0 output is registered in the same edge.
- RUN:
  - Each cycle, drive vector idx and sample dut_b for vector idx-1 (the samp_valid flag is set from the second RUN cycle).
  - idx increments each cycle.
  - After idx=15 is driven, go to DRAIN. RUN lasts exactly 16 cycles.
- DRAIN: one cycle; samples the response to vector 15; then go to DONE with done=1 for that cycle.
- Sample processing (k = sampled index):
  - On mismatch (dut_b != EXPECTED_TT[k]), fail_count+1.
  - If any_fail=0, set first_fail_vec=k and any_fail=1.
  - MISR: fb = signature[15]^dut_b; signature = {signature[14:0],1'b0} ^ (fb ? SIG_POLY : 0).
- pass is updated on the DONE entry edge only.
- Latency: start accepted to done pulse is 17 cycles (16 RUN + 1 DRAIN). The done pulse appears on cycle 18 relative to the start edge.
- DONE: holds results until the next start. DONE without start stays in DONE (done=0 after the first cycle).
- start while busy is ignored.
- abort:
  - In RUN/DRAIN: go to IDLE next edge; vectors 0; no done; pass=0; fail_count/signature frozen at partial values.
  - In IDLE/DONE: abort is ignored. abort has priority over start in the same cycle.
- Asserting rst mid-run forces the IDLE/zero state immediately. Run restarts only on a new start.
- fail_count saturates naturally at 16 and cannot overflow 5 bits.

Decomposition:
- Package bist_pkg: state enum {IDLE,RUN,DRAIN,DONE}, NUM_VEC=16, IDX_W=4, default SIG_POLY/SIG_SEED constants.
- Sub-module misr16 (clk, rst, load, seed, shift_en, din, sig): reusable compactor.
- Comparator and FSM stay in exhaustive_bist_ctrl.

Test Plan:
1. Reset then start with dut_b tied 1 (EXPECTED_TT=16'hFFFF) -> vectors 0..15 on consecutive cycles, busy high 17 cycles, done pulse once, pass=1, fail_count=0, any_fail=0, signature equals bench CRC-16/CCITT model (init FFFF) over sixteen 1s.
2. Bench model inverts b for vector 5 only -> fail_count=1, first_fail_vec=4'd5, any_fail=1, pass=0, signature differs from scenario 1.
3. dut_b tied 0 -> fail_count=16, first_fail_vec=0, pass=0.
4. abort pulsed on the 6th RUN cycle -> IDLE next edge, vectors 0, no done, pass=0. A following start produces a full clean run matching scenario 1.
5. start pulsed again during RUN and in the same cycle as abort -> ignored / abort wins; the run sequence is unchanged or cancelled respectively.
6. rst asserted mid-DRAIN asynchronously (between clock edges) -> all outputs 0 immediately. After release, idle until start; back-to-back start from DONE gives identical results.

Source files
------------

// File: rtl/exhaustive_bist_ctrl_pkg.sv
// ============================================================================
// Module   : bist_pkg
// Brief    : Shared types and constants for the exhaustive BIST controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          NUM_VEC      = 16;
  localparam int          IDX_W        = 4;
  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/exhaustive_bist_ctrl_if.sv
// ============================================================================
// Module   : exhaustive_bist_ctrl_if
// Brief    : Control, vector and result bundle of the exhaustive BIST controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface exhaustive_bist_ctrl_if;

  logic        start;
  logic        abort;
  logic        dut_x1;
  logic        dut_x2;
  logic        dut_y1;
  logic        dut_y2;
  logic        dut_b;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_count;
  logic        any_fail;
  logic [3:0]  first_fail_vec;
  logic [15:0] signature;

  // Environment side: config registers plus the function under test.
  modport master (
    output start, abort, dut_b,
    input  dut_x1, dut_x2, dut_y1, dut_y2,
    input  busy, done, pass, fail_count, any_fail, first_fail_vec, signature
  );

  modport slave (
    input  start, abort, dut_b,
    output dut_x1, dut_x2, dut_y1, dut_y2,
    output busy, done, pass, fail_count, any_fail, first_fail_vec, signature
  );

endinterface

`default_nettype wire

// File: rtl/exhaustive_bist_ctrl_misr16.sv
// ============================================================================
// Module   : misr16
// Brief    : 16-bit single-input signature register (serial response compactor).
// Revision : 1.0
// ============================================================================
`default_nettype none

module misr16
  import bist_pkg::*;
#(
  parameter logic [15:0] POLY = DEF_SIG_POLY
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic [15:0] seed,
  input  wire logic        shift_en,
  input  wire logic        din,
  output logic      [15:0] sig
);

  logic [15:0] r_sig;
  logic        w_fb;

  assign w_fb = r_sig[15] ^ din;
  assign sig  = r_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= 16'h0000;
    end else if (load) begin
      r_sig <= seed;
    end else if (shift_en) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
    end
  end

endmodule

`default_nettype wire

// File: rtl/exhaustive_bist_ctrl.sv
// ============================================================================
// Module   : exhaustive_bist_ctrl
// Brief    : Exhaustive 16-vector BIST sequencer with compare, count and MISR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exhaustive_bist_ctrl
  import bist_pkg::*;
#(
  parameter logic [15:0] EXPECTED_TT = 16'hFFFF,
  parameter logic [15:0] SIG_SEED    = DEF_SIG_SEED,
  parameter logic [15:0] SIG_POLY    = DEF_SIG_POLY
) (
  input  wire logic            clk,
  input  wire logic            rst,
  exhaustive_bist_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_VEC - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_vec;
  logic             r_samp_valid;
  logic             r_done;
  logic             r_pass;
  logic [4:0]       r_fail_count;
  logic             r_any_fail;
  logic [IDX_W-1:0] r_first_fail_vec;

  logic             w_start_ok;
  logic             w_abort;
  logic             w_sample;
  logic [IDX_W-1:0] w_samp_idx;
  logic             w_mismatch;
  logic [4:0]       w_fail_next;

  // Abort wins over start; the sample on an aborting edge is discarded.
  assign w_start_ok  = ((r_state == IDLE) || (r_state == DONE)) && bus.start && !bus.abort;
  assign w_abort     = ((r_state == RUN) || (r_state == DRAIN)) && bus.abort;
  assign w_sample    = !w_abort && (((r_state == RUN) && r_samp_valid) || (r_state == DRAIN));
  assign w_samp_idx  = (r_state == DRAIN) ? c_last_idx : (r_idx - 4'd1);
  assign w_mismatch  = w_sample && (bus.dut_b != EXPECTED_TT[w_samp_idx]);
  assign w_fail_next = r_fail_count + {4'd0, w_mismatch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_idx            <= '0;
      r_vec            <= '0;
      r_samp_valid     <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail_count     <= 5'd0;
      r_any_fail       <= 1'b0;
      r_first_fail_vec <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_mismatch) begin
        r_fail_count <= w_fail_next;
        if (!r_any_fail) begin
          r_any_fail       <= 1'b1;
          r_first_fail_vec <= w_samp_idx;
        end
      end
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state      <= RUN;
            r_idx        <= '0;
            r_vec        <= '0;
            r_samp_valid <= 1'b0;
            r_fail_count <= 5'd0;
            r_any_fail   <= 1'b0;
            r_pass       <= 1'b0;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_pass  <= 1'b0;
          end else begin
            // Response to vector idx arrives while vector idx+1 is driven.
            r_samp_valid <= 1'b1;
            if (r_idx == c_last_idx) begin
              r_state <= DRAIN;
              r_vec   <= '0;
            end else begin
              r_idx <= r_idx + 4'd1;
              r_vec <= r_idx + 4'd1;
            end
          end
        end
        DRAIN: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_pass  <= 1'b0;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_fail_next == 5'd0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  misr16 #(
    .POLY(SIG_POLY)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (w_start_ok),
    .seed    (SIG_SEED),
    .shift_en(w_sample),
    .din     (bus.dut_b),
    .sig     (bus.signature)
  );

  assign bus.dut_x1         = r_vec[3];
  assign bus.dut_x2         = r_vec[2];
  assign bus.dut_y1         = r_vec[1];
  assign bus.dut_y2         = r_vec[0];
  assign bus.busy           = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.fail_count     = r_fail_count;
  assign bus.any_fail       = r_any_fail;
  assign bus.first_fail_vec = r_first_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_exhaustive_bist_ctrl.sv
// ============================================================================
// Module   : tb_exhaustive_bist_ctrl
// Brief    : Self-checking bench: registered function-under-test model plus CRC reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exhaustive_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fut_tt;
  logic [15:0] exp_tt = 16'hFFFF;
  logic [3:0]  vec;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  exhaustive_bist_ctrl_if bif ();

  exhaustive_bist_ctrl #(
    .EXPECTED_TT(16'hFFFF),
    .SIG_SEED   (16'hFFFF),
    .SIG_POLY   (16'h1021)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  assign vec = {bif.dut_x1, bif.dut_x2, bif.dut_y1, bif.dut_y2};

  // Function under test answers one clock after a vector is presented.
  always @(posedge clk) bif.dut_b <= fut_tt[vec];

  // CRC-16/CCITT, one message bit at a time, by polynomial long division.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    int t;
    t = int'(c) * 2;
    if ((((t >> 16) & 1) != 0) != b) t = t ^ 32'h1021;
    return t[15:0];
  endfunction

  // Expected results after the first n responses of truth table tt.
  task automatic model(input logic [15:0] tt, input int n, output logic [4:0] fc,
                       output logic af, output logic [3:0] ff, output logic [15:0] sig);
    fc = 5'd0; af = 1'b0; ff = 4'd0; sig = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      if (tt[k] != exp_tt[k]) begin
        fc = fc + 5'd1;
        if (!af) begin af = 1'b1; ff = k[3:0]; end
      end
      sig = crc_step(sig, tt[k]);
    end
  endtask

  task automatic do_full_run(input logic [15:0] tt, input int extra_start_cyc, input string name);
    logic [4:0]  efc;
    logic        eaf;
    logic [3:0]  eff;
    logic [15:0] esig;
    logic [3:0]  ev;
    model(tt, 16, efc, eaf, eff, esig);
    fut_tt = tt;
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      ev = (c <= 16) ? 4'(c - 1) : 4'd0;
      total++;
      if (vec !== ev) begin bad++; $display("FAIL %s vec cyc%0d got=%0d exp=%0d", name, c, vec, ev); end
      total++;
      if (bif.busy !== 1'(c <= 17)) begin bad++; $display("FAIL %s busy cyc%0d got=%b exp=%b", name, c, bif.busy, (c <= 17)); end
      total++;
      if (bif.done !== 1'(c == 18)) begin bad++; $display("FAIL %s done cyc%0d got=%b exp=%b", name, c, bif.done, (c == 18)); end
      bif.start = (c == extra_start_cyc);
      if (c < 18) @(negedge clk);
    end
    bif.start = 1'b0;
    total++;
    if (bif.fail_count !== efc) begin bad++; $display("FAIL %s fail_count got=%0d exp=%0d", name, bif.fail_count, efc); end
    total++;
    if (bif.any_fail !== eaf) begin bad++; $display("FAIL %s any_fail got=%b exp=%b", name, bif.any_fail, eaf); end
    if (eaf) begin
      total++;
      if (bif.first_fail_vec !== eff) begin bad++; $display("FAIL %s first_fail_vec got=%0d exp=%0d", name, bif.first_fail_vec, eff); end
    end
    total++;
    if (bif.pass !== (efc == 5'd0)) begin bad++; $display("FAIL %s pass got=%b exp=%b", name, bif.pass, (efc == 5'd0)); end
    total++;
    if (bif.signature !== esig) begin bad++; $display("FAIL %s signature got=%h exp=%h", name, bif.signature, esig); end
    @(negedge clk);
    total++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin bad++; $display("FAIL %s hold done/busy got=%b/%b exp=0/0", name, bif.done, bif.busy); end
    total++;
    if (bif.signature !== esig) begin bad++; $display("FAIL %s held signature got=%h exp=%h", name, bif.signature, esig); end
  endtask

  task automatic test_reset;
    rst = 1'b1; bif.start = 1'b0; bif.abort = 1'b0; fut_tt = 16'hFFFF;
    repeat (2) @(negedge clk);
    total++;
    if ({bif.busy, bif.done, bif.pass, bif.any_fail, vec, bif.fail_count, bif.first_fail_vec, bif.signature} !== '0) begin
      bad++; $display("FAIL reset outputs got busy=%b done=%b pass=%b sig=%h fc=%0d exp=all zero",
                      bif.busy, bif.done, bif.pass, bif.signature, bif.fail_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ones;   do_full_run(16'hFFFF, 0, "all_ones");        endtask
  task automatic test_single_fail; do_full_run(16'hFFDF, 0, "single_fail_v5"); endtask
  task automatic test_all_zero;   do_full_run(16'h0000, 0, "all_zero");        endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) do_full_run(16'($urandom()), 0, "random");
  endtask

  task automatic test_start_while_busy;
    do_full_run(16'($urandom()), 8, "start_busy");
  endtask

  task automatic test_abort(input logic [15:0] tt, input int abort_cyc, input logic with_start, input string name);
    logic [4:0]  efc;
    logic        eaf;
    logic [3:0]  eff;
    logic [15:0] esig;
    logic        seen;
    model(tt, abort_cyc - 2, efc, eaf, eff, esig);
    fut_tt = tt;
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    repeat (abort_cyc - 1) @(negedge clk);
    total++;
    if (vec !== 4'(abort_cyc - 1) || bif.busy !== 1'b1) begin
      bad++; $display("FAIL %s pre-abort vec/busy got=%0d/%b exp=%0d/1", name, vec, bif.busy, abort_cyc - 1);
    end
    bif.abort = 1'b1; bif.start = with_start;
    @(negedge clk);
    bif.abort = 1'b0; bif.start = 1'b0;
    total++;
    if (bif.busy !== 1'b0 || vec !== 4'd0 || bif.done !== 1'b0 || bif.pass !== 1'b0) begin
      bad++; $display("FAIL %s post-abort busy=%b vec=%0d done=%b pass=%b exp=0/0/0/0", name, bif.busy, vec, bif.done, bif.pass);
    end
    total++;
    if (bif.fail_count !== efc) begin bad++; $display("FAIL %s partial fail_count got=%0d exp=%0d", name, bif.fail_count, efc); end
    total++;
    if (bif.signature !== esig) begin bad++; $display("FAIL %s partial signature got=%h exp=%h", name, bif.signature, esig); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.done !== 1'b0 || bif.busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL %s activity after abort got=1 exp=0", name); end
    do_full_run(16'hFFFF, 0, "after_abort");
  endtask

  task automatic test_reset_mid_drain;
    fut_tt = 16'h5A5A;
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    repeat (16) @(negedge clk);
    total++;
    if (bif.busy !== 1'b1 || vec !== 4'd0) begin bad++; $display("FAIL drain_state busy/vec got=%b/%0d exp=1/0", bif.busy, vec); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bif.busy, bif.done, bif.pass, bif.any_fail, vec, bif.fail_count, bif.signature} !== '0) begin
      bad++; $display("FAIL async_reset outputs busy=%b sig=%h fc=%0d any=%b exp=all zero",
                      bif.busy, bif.signature, bif.fail_count, bif.any_fail);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy/done got=%b/%b exp=0/0", bif.busy, bif.done); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] tt;
    tt = 16'($urandom());
    do_full_run(tt, 0, "b2b_first");
    do_full_run(tt, 0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_fail();
    test_all_zero();
    test_random();
    test_abort(16'($urandom()), 6, 1'b0, "abort_c6");
    test_start_while_busy();
    test_abort(16'($urandom()), 10, 1'b1, "abort_with_start");
    test_reset_mid_drain();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
